uart_serial_core: RTL and testbench
===================================

# uart_serial_core

Single-clock 8N1 UART serial core: a 16× baud tick generator, a transmitter and an oversampling receiver behind a byte-wide handshake. It sits between the board pins (`rxd`/`txd`) and the byte-level control logic that decides what to send, for example an echo/transform controller. It replaces the divided-clock arrangement: all logic runs on `sysclk` and advances only on the internal tick enable.

## Interface
- `TICK_DIV`, default 651: `sysclk` cycles per 16× baud tick. 100 MHz / (16 × 9600) ≈ 651. Legal range is ≥ 2.
- `sysclk` in, 1: system clock, rising edge.
- `reset` in, 1: **asynchronous, active-high** reset.
- `rxd` in, 1: serial input, asynchronous to `sysclk`, idle high.
- `txd` out, 1: serial output, idle high.
- `tx_data` in, 8: byte to transmit; sampled at accept.
- `tx_en` in, 1: transmit request; accepted only while `tx_status`=1.
- `tx_status` out, 1: 1 = transmitter idle/ready, 0 = frame in progress.
- `rx_data` out, 8: last correctly framed received byte; held until the next good byte.
- `rx_status` out, 1: one-`sysclk` pulse when `rx_data` has just been updated.

## Operation
- **Tick generator.** Counter 0..`TICK_DIV`-1 wraps. `tick`=1 for exactly one cycle when counter = `TICK_DIV`-1. Reset sets counter to 0.
- **Frame format.** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts 16 ticks. A frame is 160 ticks.
- **TX states:** IDLE, START, DATA, STOP.
  - IDLE: `txd`=1, `tx_status`=1.
  - Accept: on a `sysclk` edge with `tx_status`=1 and `tx_en`=1, latch `tx_data` into the shift register and go to START. `tx_status`=0 from the next cycle.
  - Bit timing: the START bit begins on the first tick after accept and holds for 16 ticks. DATA then sends bits 0..7 at 16 ticks each. STOP drives 1 for 16 ticks, then returns to IDLE with `tx_status`=1.
  - Busy requests: `tx_en` while `tx_status`=0 is ignored. Changes to `tx_data` after accept do not affect the frame in flight.
  - Holding `tx_en` high continuously sends back-to-back frames, re-accepting on the first cycle `tx_status` returns to 1.
- **RX path.** `rxd` passes through a 2-flop synchronizer before any use.
- **RX states:** IDLE, START, DATA, STOP.
  - IDLE: on a tick where the synchronized `rxd`=0, go to START with the tick count cleared.
  - START: at the 8th tick (mid-bit), re-sample. If 1, it is a false start: return to IDLE with no output change. If 0, go to DATA.
  - DATA: sample every 16 ticks (mid-bit), shifting in LSB first, 8 samples.
  - STOP: sample 16 ticks after the last data bit.
    - If 1: load `rx_data`, pulse `rx_status` for one `sysclk` cycle, return to IDLE.
    - If 0 (framing error): discard the byte, leave `rx_data` unchanged, give no pulse, and return to IDLE only after `rxd` has been sampled high (break handling).
  - Because RX returns to IDLE at the stop-bit midpoint, back-to-back frames are received.
- **RX/TX independence.** RX and TX share only the tick and run fully independently (full duplex).

## Timing
- **Reset values:** `txd`=1, `tx_status`=1, `rx_data`=8'h00, `rx_status`=0. Both FSMs go to IDLE and the tick counter to 0.
- **Reset mid-frame:** aborts immediately. `txd` goes to 1 asynchronously and any partial RX byte is discarded.
- **TX latency:** accept → `txd` falling edge occurs at the first tick after accept, at most `TICK_DIV` cycles later. `tx_status` is low for 160 ticks plus up to one tick of alignment.
- **RX latency:** `rx_status` pulses about 9.5 bit-times after the start-bit falling edge, ±1 tick of sampling jitter plus 2 synchronizer cycles.
- **Simultaneous events:** a `tx_en` accept on the same cycle as an RX completion is unaffected. A new start edge in the cycle after the stop-sample is detected normally.

## Test plan
- **Reset:** assert `reset` mid-TX-frame (`tx_data`=8'hA5). Required: `txd`=1, `tx_status`=1, `rx_data`=00 and `rx_status`=0 immediately; no residual bits after release.
- **TX 8'h55:** pulse `tx_en` while idle. Required: `txd` = 0,1,0,1,0,1,0,1,0,1, each 16 × `TICK_DIV` cycles. `tx_status` low throughout, then high.
- **RX 8'hA5:** drive `rxd` with a correctly timed 8N1 frame. Required: exactly one `rx_status` pulse, `rx_data`=8'hA5, held through a following idle period.
- **False start:** drive a 0 glitch on `rxd` of 4 ticks, then a valid 8'h3C frame. Required: no pulse for the glitch; a single pulse with `rx_data`=8'h3C afterwards.
- **Framing error:** send 8'h81 with stop bit 0. Required: no `rx_status` pulse, `rx_data` unchanged. After `rxd` returns high, the next good byte 8'h12 is received.
- **Busy and loopback:** tie `txd`→`rxd`. Pulse `tx_en` with 8'h7E, then pulse `tx_en` with 8'hFF while `tx_status`=0. Required: only 8'h7E is sent and received (`rx_data`=8'h7E); the 8'hFF request is ignored.

Source files
------------

// File: rtl/uart_serial_core.sv
// uart_serial_core: single-clock 8N1 UART with a shared 16x baud tick,
// a transmitter and a mid-bit oversampling receiver.
module uart_serial_core #(
   parameter int unsigned TICK_DIV = 651
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       rxd,
   output logic       txd,
   input  logic [7:0] tx_data,
   input  logic       tx_en,
   output logic       tx_status,
   output logic [7:0] rx_data,
   output logic       rx_status
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   logic [CNT_W-1:0] div_q;
   logic             tick_c;

   logic [1:0] tx_state_q, tx_state_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic [3:0] tx_tc_q, tx_tc_d;
   logic [2:0] tx_bit_q, tx_bit_d;
   logic       txd_d, tx_status_d;

   logic       rx_meta_q, rx_s_q;
   logic [1:0] rx_state_q, rx_state_d;
   logic [7:0] rx_sh_q, rx_sh_d;
   logic [3:0] rx_tc_q, rx_tc_d;
   logic [2:0] rx_bit_q, rx_bit_d;
   logic       rx_err_q, rx_err_d;
   logic [7:0] rx_data_d;
   logic       rx_status_d;

   // Baud tick divider: one-cycle tick every TICK_DIV sysclk cycles
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset)
         div_q <= '0;
      else if (div_q == CNT_W'(TICK_DIV - 1))
         div_q <= '0;
      else
         div_q <= div_q + CNT_W'(1);
   end

   assign tick_c = (div_q == CNT_W'(TICK_DIV - 1));

   // TX next-state: START waits for the first tick (txd still high) before falling
   always_comb begin
      tx_state_d  = tx_state_q;
      tx_sh_d     = tx_sh_q;
      tx_tc_d     = tx_tc_q;
      tx_bit_d    = tx_bit_q;
      txd_d       = txd;
      tx_status_d = tx_status;
      case (tx_state_q)
         TX_IDLE: begin
            txd_d       = 1'b1;
            tx_status_d = 1'b1;
            if (tx_en && tx_status) begin
               tx_sh_d     = tx_data;
               tx_status_d = 1'b0;
               tx_state_d  = TX_START;
            end
         end
         TX_START: begin
            if (tick_c) begin
               if (txd) begin
                  txd_d   = 1'b0;
                  tx_tc_d = 4'd0;
               end else if (tx_tc_q == 4'd15) begin
                  txd_d      = tx_sh_q[0];
                  tx_sh_d    = {1'b0, tx_sh_q[7:1]};
                  tx_bit_d   = 3'd0;
                  tx_tc_d    = 4'd0;
                  tx_state_d = TX_DATA;
               end else begin
                  tx_tc_d = tx_tc_q + 4'd1;
               end
            end
         end
         TX_DATA: begin
            if (tick_c) begin
               if (tx_tc_q == 4'd15) begin
                  tx_tc_d = 4'd0;
                  if (tx_bit_q == 3'd7) begin
                     txd_d      = 1'b1;
                     tx_state_d = TX_STOP;
                  end else begin
                     txd_d    = tx_sh_q[0];
                     tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                     tx_bit_d = tx_bit_q + 3'd1;
                  end
               end else begin
                  tx_tc_d = tx_tc_q + 4'd1;
               end
            end
         end
         TX_STOP: begin
            if (tick_c) begin
               if (tx_tc_q == 4'd15) begin
                  tx_tc_d     = 4'd0;
                  tx_status_d = 1'b1;
                  tx_state_d  = TX_IDLE;
               end else begin
                  tx_tc_d = tx_tc_q + 4'd1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // TX registers; reset forces the line idle immediately
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         tx_state_q <= TX_IDLE;
         tx_sh_q    <= 8'h00;
         tx_tc_q    <= 4'd0;
         tx_bit_q   <= 3'd0;
         txd        <= 1'b1;
         tx_status  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_sh_q    <= tx_sh_d;
         tx_tc_q    <= tx_tc_d;
         tx_bit_q   <= tx_bit_d;
         txd        <= txd_d;
         tx_status  <= tx_status_d;
      end
   end

   // Two-flop synchronizer for the asynchronous serial input
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rxd;
         rx_s_q    <= rx_meta_q;
      end
   end

   // RX next-state: mid-bit sampling; a bad stop bit waits for the line to go high
   always_comb begin
      rx_state_d  = rx_state_q;
      rx_sh_d     = rx_sh_q;
      rx_tc_d     = rx_tc_q;
      rx_bit_d    = rx_bit_q;
      rx_err_d    = rx_err_q;
      rx_data_d   = rx_data;
      rx_status_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_err_d = 1'b0;
            if (tick_c && !rx_s_q) begin
               rx_tc_d    = 4'd0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (tick_c) begin
               if (rx_tc_q == 4'd7) begin
                  rx_tc_d  = 4'd0;
                  rx_bit_d = 3'd0;
                  rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_tc_d = rx_tc_q + 4'd1;
               end
            end
         end
         RX_DATA: begin
            if (tick_c) begin
               if (rx_tc_q == 4'd15) begin
                  rx_tc_d = 4'd0;
                  rx_sh_d = {rx_s_q, rx_sh_q[7:1]};
                  if (rx_bit_q == 3'd7)
                     rx_state_d = RX_STOP;
                  else
                     rx_bit_d = rx_bit_q + 3'd1;
               end else begin
                  rx_tc_d = rx_tc_q + 4'd1;
               end
            end
         end
         RX_STOP: begin
            if (tick_c) begin
               if (rx_err_q) begin
                  if (rx_s_q) begin
                     rx_err_d   = 1'b0;
                     rx_state_d = RX_IDLE;
                  end
               end else if (rx_tc_q == 4'd15) begin
                  rx_tc_d = 4'd0;
                  if (rx_s_q) begin
                     rx_data_d   = rx_sh_q;
                     rx_status_d = 1'b1;
                     rx_state_d  = RX_IDLE;
                  end else begin
                     rx_err_d = 1'b1;
                  end
               end else begin
                  rx_tc_d = rx_tc_q + 4'd1;
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // RX registers
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         rx_sh_q    <= 8'h00;
         rx_tc_q    <= 4'd0;
         rx_bit_q   <= 3'd0;
         rx_err_q   <= 1'b0;
         rx_data    <= 8'h00;
         rx_status  <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_sh_q    <= rx_sh_d;
         rx_tc_q    <= rx_tc_d;
         rx_bit_q   <= rx_bit_d;
         rx_err_q   <= rx_err_d;
         rx_data    <= rx_data_d;
         rx_status  <= rx_status_d;
      end
   end

endmodule

// File: tb/tb_uart_serial_core.sv
// Directed bench for uart_serial_core with a small tick divider.
module tb_uart_serial_core;

   localparam int unsigned TD  = 4;
   localparam int unsigned BIT = 16 * TD;

   logic       sysclk;
   logic       reset;
   logic       rxd;
   logic       rxd_drv;
   logic       loop;
   logic       txd;
   logic [7:0] tx_data;
   logic       tx_en;
   logic       tx_status;
   logic [7:0] rx_data;
   logic       rx_status;

   int n_assert;
   int n_fail;
   int pulses;

   assign rxd = loop ? txd : rxd_drv;

   uart_serial_core #(.TICK_DIV(TD)) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .rxd       (rxd),
      .txd       (txd),
      .tx_data   (tx_data),
      .tx_en     (tx_en),
      .tx_status (tx_status),
      .rx_data   (rx_data),
      .rx_status (rx_status)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // Count rx_status pulses, sampled away from the active edge
   always @(negedge sysclk) begin
      if (rx_status === 1'b1) pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rxd_drv = 1'b0;
      cyc(BIT);
      for (int i = 0; i < 8; i++) begin
         rxd_drv = b[i];
         cyc(BIT);
      end
      rxd_drv = stop_bit;
      cyc(BIT);
      rxd_drv = 1'b1;
   endtask

   task automatic pulse_tx(input logic [7:0] b);
      tx_data = b;
      tx_en   = 1'b1;
      cyc(1);
      tx_en   = 1'b0;
   endtask

   initial begin
      int k;
      int p0;
      int lows;
      logic [9:0] exp_bits;
      n_assert = 0;
      n_fail   = 0;
      pulses   = 0;
      reset    = 1'b1;
      rxd_drv  = 1'b1;
      loop     = 1'b0;
      tx_data  = 8'h00;
      tx_en    = 1'b0;
      cyc(3);
      check("reset_txd", txd, 1);
      check("reset_tx_status", tx_status, 1);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_status", rx_status, 0);
      reset = 1'b0;
      cyc(5);

      // TX 8'h55: start, LSB-first data, stop
      pulse_tx(8'h55);
      k = 0;
      while (txd !== 1'b0 && k < 2 * TD + 4) begin cyc(1); k++; end
      check("tx55_fall", txd, 0);
      exp_bits = 10'b10_1010_1010;
      cyc(8 * TD);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("tx55_bit%0d", i), txd, exp_bits[i]);
         check($sformatf("tx55_busy%0d", i), tx_status, 0);
         if (i < 9) cyc(BIT);
      end
      k = 0;
      while (tx_status !== 1'b1 && k < 10 * TD + 4) begin cyc(1); k++; end
      check("tx55_done", tx_status, 1);
      check("tx55_idle_line", txd, 1);
      cyc(3 * BIT);

      // RX 8'hA5, then hold through idle
      p0 = pulses;
      send_frame(8'hA5, 1'b1);
      check("rxA5_pulses", pulses - p0, 1);
      check("rxA5_data", rx_data, 8'hA5);
      cyc(3 * BIT);
      check("rxA5_hold", rx_data, 8'hA5);
      check("rxA5_no_extra", pulses - p0, 1);

      // False start: 4-tick glitch then a valid 8'h3C
      p0 = pulses;
      rxd_drv = 1'b0;
      cyc(4 * TD);
      rxd_drv = 1'b1;
      cyc(20 * TD);
      check("glitch_no_pulse", pulses - p0, 0);
      check("glitch_data", rx_data, 8'hA5);
      send_frame(8'h3C, 1'b1);
      check("rx3C_pulses", pulses - p0, 1);
      check("rx3C_data", rx_data, 8'h3C);
      cyc(2 * BIT);

      // Framing error on 8'h81, then good 8'h12
      p0 = pulses;
      send_frame(8'h81, 1'b0);
      cyc(BIT);
      check("ferr_no_pulse", pulses - p0, 0);
      check("ferr_data", rx_data, 8'h3C);
      send_frame(8'h12, 1'b1);
      check("rx12_pulses", pulses - p0, 1);
      check("rx12_data", rx_data, 8'h12);
      cyc(2 * BIT);

      // Loopback with an ignored busy request
      loop = 1'b1;
      cyc(4);
      p0 = pulses;
      pulse_tx(8'h7E);
      cyc(5);
      check("loop_busy", tx_status, 0);
      pulse_tx(8'hFF);
      k = 0;
      while (tx_status !== 1'b1 && k < 170 * TD + 10) begin cyc(1); k++; end
      check("loop_done", tx_status, 1);
      cyc(4);
      check("loop_pulses", pulses - p0, 1);
      check("loop_data", rx_data, 8'h7E);
      lows = 0;
      for (int i = 0; i < 3 * BIT; i++) begin
         cyc(1);
         if (txd !== 1'b1) lows++;
      end
      check("loop_no_second_frame", lows, 0);
      check("loop_pulses_after", pulses - p0, 1);
      loop = 1'b0;

      // Reset in the middle of a TX frame
      pulse_tx(8'hA5);
      cyc(40 * TD);
      check("midframe_busy", tx_status, 0);
      reset = 1'b1;
      #1;
      check("midreset_txd", txd, 1);
      check("midreset_tx_status", tx_status, 1);
      check("midreset_rx_data", rx_data, 8'h00);
      check("midreset_rx_status", rx_status, 0);
      cyc(3);
      reset = 1'b0;
      lows = 0;
      p0 = pulses;
      for (int i = 0; i < 12 * BIT; i++) begin
         cyc(1);
         if (txd !== 1'b1 || tx_status !== 1'b1) lows++;
      end
      check("postreset_quiet", lows, 0);
      check("postreset_rx_data", rx_data, 8'h00);
      check("postreset_no_pulse", pulses - p0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
